// File: rtl/serial_adder.sv
// serial_adder: bit-serial, LSB-first WIDTH-bit adder with carry-in.
// One full-adder cell and a carry flop do the work over WIDTH clock cycles.
// The adder sits behind a start/done handshake.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   start  - request pulse; sampled only in IDLE or DONE
//   a, b   - WIDTH-bit operands, captured when start is accepted
//   cin    - carry-in, captured when start is accepted
//   busy   - high while an addition is in progress
//   done   - one-cycle pulse when the result is loaded
//   sum    - registered WIDTH-bit result, held until the next completion
//   cout   - carry out of the MSB, held with sum
//   ovf    - signed overflow (carry into MSB xor cout), held with sum
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StAdd,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] ps_q, ps_d;
    logic             cy_q, cy_d;
    logic             cm_q, cm_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    // The single full-adder cell.
    logic s_bit, c_bit;
    assign s_bit = sa_q[0] ^ sb_q[0] ^ cy_q;
    assign c_bit = (sa_q[0] & sb_q[0]) | (cy_q & (sa_q[0] ^ sb_q[0]));

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        ps_d    = ps_q;
        cy_d    = cy_q;
        cm_d    = cm_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    cy_d    = cin;
                    cnt_d   = '0;
                    ps_d    = '0;
                    state_d = StAdd;
                end else begin
                    state_d = StIdle;
                end
            end
            StAdd: begin
                ps_d  = {s_bit, ps_q[WIDTH-1:1]};
                sa_d  = {1'b0, sa_q[WIDTH-1:1]};
                sb_d  = {1'b0, sb_q[WIDTH-1:1]};
                cy_d  = c_bit;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntLast) begin
                    // cy_q is the carry into the MSB on this edge.
                    cm_d    = cy_q;
                    sum_d   = {s_bit, ps_q[WIDTH-1:1]};
                    cout_d  = c_bit;
                    cnt_d   = '0;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sa_q    <= '0;
            sb_q    <= '0;
            ps_q    <= '0;
            cy_q    <= 1'b0;
            cm_q    <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            ps_q    <= ps_d;
            cy_q    <= cy_d;
            cm_q    <= cm_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == StAdd);
    assign done = (state_q == StDone);
    assign sum  = sum_q;
    assign cout = cout_q;
    // cm and cout load on the same edge and are held together, so their xor
    // is the overflow of the last completed addition (and 0 after reset).
    assign ovf  = cm_q ^ cout_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 8-bit instance
    logic       start8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] sum8;

    // 2-bit instance
    logic       start2 = 1'b0, cin2 = 1'b0;
    logic [1:0] a2 = '0, b2 = '0;
    logic       busy2, done2, cout2, ovf2;
    logic [1:0] sum2;

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] get_sum(input int w);
        return (w == 8) ? 32'(sum8) : 32'(sum2);
    endfunction
    function automatic logic get_cout(input int w);
        return (w == 8) ? cout8 : cout2;
    endfunction
    function automatic logic get_ovf(input int w);
        return (w == 8) ? ovf8 : ovf2;
    endfunction
    function automatic logic get_busy(input int w);
        return (w == 8) ? busy8 : busy2;
    endfunction
    function automatic logic get_done(input int w);
        return (w == 8) ? done8 : done2;
    endfunction

    task automatic drive(input int w, input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic tc, input logic ts);
        if (w == 8) begin
            a8 = ta[7:0]; b8 = tb_v[7:0]; cin8 = tc; start8 = ts;
        end else begin
            a2 = ta[1:0]; b2 = tb_v[1:0]; cin2 = tc; start2 = ts;
        end
    endtask

    // Reference: plain unsigned and signed integer arithmetic.
    task automatic ref_add(input int w, input longint ua, input longint ub, input longint uc,
                           output logic [31:0] esum, output logic ecout, output logic eovf);
        longint total, sa, sb, st, half, full;
        full  = longint'(1) << w;
        half  = full / 2;
        total = ua + ub + uc;
        esum  = 32'(total % full);
        ecout = (total >= full);
        sa    = (ua >= half) ? ua - full : ua;
        sb    = (ub >= half) ? ub - full : ub;
        st    = sa + sb + uc;
        eovf  = (st < -half) || (st > half - 1);
    endtask

    // One complete operation with full cycle-by-cycle checking.
    task automatic do_op(input int w, input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic tc, input string tag);
        logic [31:0] prev_sum, es;
        logic        prev_cout, prev_ovf, ec, eo;
        prev_sum  = get_sum(w);
        prev_cout = get_cout(w);
        prev_ovf  = get_ovf(w);
        ref_add(w, longint'(ta), longint'(tb_v), longint'(tc), es, ec, eo);
        drive(w, ta, tb_v, tc, 1'b1);
        @(posedge clk); #1;
        // Scramble operands after acceptance; the result must not change.
        drive(w, $urandom, $urandom, 1'($urandom), 1'b0);
        check({tag, " busy@E0"}, 32'(get_busy(w)), 32'd1);
        for (int i = 1; i < w; i++) begin
            @(posedge clk); #1;
            check({tag, " busy"}, 32'(get_busy(w)), 32'd1);
            check({tag, " done early"}, 32'(get_done(w)), 32'd0);
            check({tag, " sum held"}, get_sum(w), prev_sum);
            check({tag, " cout/ovf held"}, {30'd0, get_cout(w), get_ovf(w)},
                  {30'd0, prev_cout, prev_ovf});
        end
        @(posedge clk); #1;
        check({tag, " done"}, {30'd0, get_done(w), get_busy(w)}, 32'b10);
        check({tag, " sum"}, get_sum(w), es);
        check({tag, " cout"}, 32'(get_cout(w)), 32'(ec));
        check({tag, " ovf"}, 32'(get_ovf(w)), 32'(eo));
        @(posedge clk); #1;
        check({tag, " done fall"}, {30'd0, get_done(w), get_busy(w)}, 32'b00);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rc;

        // Reset state
        #2;
        check("reset outputs8", {busy8, done8, sum8, cout8, ovf8}, 32'd0);
        check("reset outputs2", {busy2, done2, sum2, cout2, ovf2}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle after reset", {busy8, done8}, 32'd0);

        // Directed operations, WIDTH=8
        do_op(8, 32'h35, 32'h4A, 1'b0, "t1 35+4A");
        do_op(8, 32'hFF, 32'h01, 1'b0, "t2 FF+01");
        do_op(8, 32'h7F, 32'h01, 1'b0, "t2 7F+01");
        do_op(8, 32'h80, 32'h80, 1'b0, "t2 80+80");
        do_op(8, 32'h00, 32'h00, 1'b1, "t3 00+00+1");
        do_op(8, 32'hFF, 32'hFF, 1'b1, "t3 FF+FF+1");

        // Start during ADD ignored; start held through DONE accepted back-to-back
        drive(8, 32'h10, 32'h20, 1'b0, 1'b1);
        @(posedge clk); #1;                     // E0
        start8 = 1'b0;
        @(posedge clk); #1;                     // E1
        @(posedge clk); #1;                     // E2
        drive(8, 32'h55, 32'h55, 1'b0, 1'b1);
        @(posedge clk); #1;                     // E3
        start8 = 1'b0;
        check("t4 busy after ignored start", 32'(busy8), 32'd1);
        for (int e = 4; e < 8; e++) begin
            @(posedge clk); #1;
            check("t4 no early done", {busy8, done8}, 32'b10);
        end
        @(posedge clk); #1;                     // E8
        check("t4 done E8", {busy8, done8}, 32'b01);
        check("t4 sum 30", 32'(sum8), 32'h30);
        drive(8, 32'h55, 32'h55, 1'b0, 1'b1);
        @(posedge clk); #1;                     // E9
        start8 = 1'b0;
        check("t4 b2b accept E9", {busy8, done8}, 32'b10);
        for (int e = 10; e < 17; e++) begin
            @(posedge clk); #1;
            check("t4 b2b busy", {busy8, done8}, 32'b10);
            check("t4 b2b sum held", 32'(sum8), 32'h30);
        end
        @(posedge clk); #1;                     // E17
        check("t4 done E17", {busy8, done8}, 32'b01);
        check("t4 sum AA", {sum8, cout8, ovf8}, {8'hAA, 1'b0, 1'b1});
        @(posedge clk); #1;
        check("t4 idle", {busy8, done8}, 32'b00);

        // Asynchronous reset mid-operation
        drive(8, 32'hAA, 32'h11, 1'b0, 1'b1);
        @(posedge clk); #1;                     // E0
        start8 = 1'b0;
        repeat (4) @(posedge clk);              // E4
        #3;
        rst_n = 1'b0;
        #1;
        check("t5 reset abort", {busy8, done8, sum8, cout8, ovf8}, 32'd0);
        #2;
        rst_n = 1'b1;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk); #1;
            check("t5 no done after reset", {busy8, done8, sum8}, 32'd0);
        end
        do_op(8, 32'hAA, 32'h11, 1'b0, "t5 fresh AA+11");

        // WIDTH=2 directed
        do_op(2, 32'd3, 32'd3, 1'b1, "t6 w2 3+3+1");
        do_op(2, 32'd1, 32'd1, 1'b0, "t6 w2 1+1");

        // Random sweeps against the reference model
        for (int n = 0; n < 1000; n++) begin
            ra = $urandom_range(255);
            rb = $urandom_range(255);
            rc = 1'($urandom);
            do_op(8, ra, rb, rc, "rand w8");
        end
        for (int n = 0; n < 1000; n++) begin
            ra = $urandom_range(3);
            rb = $urandom_range(3);
            rc = 1'($urandom);
            do_op(2, ra, rb, rc, "rand w2");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
